// File: rtl/serial_bit_tx.sv
// Single-wire UART-style transmitter: start bit, DATA_W data bits LSB-first,
// then one or two stop bits. The line idles high, and reset forces it high at once.
module serial_bit_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DIV_W-1:0]  div,
    input  logic              nstop,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    w_cnt_nxt;
    logic [DIV_W-1:0]    r_div_s;
    logic [DIV_W-1:0]    w_div_s_nxt;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [IDX_W-1:0]    w_bit_idx_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                r_nstop_s;
    logic                w_nstop_s_nxt;
    logic                r_stop_idx;
    logic                w_stop_idx_nxt;
    logic                r_tx;
    logic                w_tx_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                w_bit_end;

    // Last cycle of the current bit period.
    assign w_bit_end = (r_cnt == r_div_s);

    assign in_ready = (r_state == S_IDLE);
    assign tx       = r_tx;
    assign busy     = r_busy;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div_s    <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_nstop_s  <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div_s    <= w_div_s_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_nstop_s  <= w_nstop_s_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic; the tx level for each bit is set on the
    // edge that starts that bit, so the line is a clean register output.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = w_bit_end ? '0 : r_cnt + DIV_W'(1);
        w_div_s_nxt    = r_div_s;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_nstop_s_nxt  = r_nstop_s;
        w_stop_idx_nxt = r_stop_idx;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (in_valid) begin
                    w_state_nxt    = S_START;
                    w_shift_nxt    = in_data;
                    w_div_s_nxt    = div;
                    w_nstop_s_nxt  = nstop;
                    w_bit_idx_nxt  = '0;
                    w_stop_idx_nxt = 1'b0;
                    w_tx_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == IDX_W'(DATA_W - 1)) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end

            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    if (r_stop_idx == r_nstop_s) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/serial_bit_tx.md
Name: serial_bit_tx

Overview:
- Single-wire serial transmitter. Takes parallel words over a valid/ready handshake and drives them onto one output wire, UART-style: start bit, data LSB-first, 1 or 2 stop bits.
- Source end of the one-bit pass-through links in the subsystem. Its output feeds those wires directly, and the receiver at the far end samples the line.

Parameters:
- DATA_W, 8, data bits per frame (legal 5..16)
- DIV_W, 16, width of bit-period divisor

Ports:
- clock  input  1  block clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  word offered
- in_ready  output  1  block can accept a word
- in_data  input  DATA_W  word to send, bit 0 first
- div  input  DIV_W  bit period minus one, in clock cycles
- nstop  input  1  0: one stop bit, 1: two stop bits
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress

Behaviour:
- Reset values (asynchronous, immediate on reset_n low):
  - tx=1, busy=0, in_ready=1
  - state=IDLE, counters=0
- States: IDLE, START, DATA, STOP.
- in_ready = (state==IDLE), combinational from the state register only; no combinational path from in_valid.
- Accept: in the cycle where in_valid & in_ready are both high, latch in_data, div and nstop into shadow registers.
  - The next edge enters START; tx (registered) goes 0 and busy=1.
  - Latency is 1 cycle from acceptance to the start-bit edge.
- Bit timing:
  - Each bit is held exactly div_s+1 cycles, where div_s is the latched div.
  - div_s=0 gives 1 cycle per bit; maximum is 2^DIV_W cycles per bit.
  - The cycle counter counts 0..div_s and wraps to 0 at each bit boundary.
- START: 1 bit time at tx=0, then DATA.
- DATA:
  - Shift register outputs bit 0 first, then bit 1, and so on.
  - The bit index counts 0..DATA_W-1.
  - After bit DATA_W-1 expires, go to STOP.
- STOP: tx=1 for (1+nstop_s) bit times, then IDLE with busy=0.
- Back-to-back frames:
  - IDLE lasts at least 1 cycle with tx=1 between frames.
  - With in_valid held high, the frame-to-frame period is exactly (2+DATA_W+nstop)*(div+1)+1 cycles.
- Changes to div, nstop or in_data while busy have no effect on the current frame.
- in_valid while busy: the word is not accepted. The source must hold it until in_ready; in_data is sampled only at acceptance.
- Reset mid-frame: tx returns to 1 asynchronously and the frame is discarded with no partial completion. After release the block is in IDLE and accepts a new word in the first cycle.
- No X propagation: tx is always 0 or 1 out of reset.

Test Plan:
1. Reset asserted then released, no stimulus -> tx=1, busy=0, in_ready=1 held for 100 cycles.
2. DATA_W=8, div=3, nstop=0, send 0xA5 -> 4-cycle bits: tx sequence 0 | 1,0,1,0,0,1,0,1 | 1, i.e. 40 cycles with busy=1; start edge 1 cycle after the acceptance cycle; in_ready returns 1 after 40 cycles.
3. div=0, nstop=1, in_valid held with 0x00 then 0xFF -> each frame 11 cycles (0, eight 0s, 1, 1), then 1 idle cycle, then the second frame (0, eight 1s, 1, 1); second acceptance exactly 12 cycles after the first.
4. Send 0x3C with div=2, change div to 9, nstop to 1 and in_data mid-frame -> frame still uses 3-cycle bits and one stop bit (30 cycles), content 0x3C; the next frame uses the new values.
5. reset_n low during DATA bit 4 of a div=5 frame -> tx=1 and busy=0 in the same cycle without waiting for a clock edge; after release, 0x81 is accepted immediately and transmitted correctly.
6. in_valid asserted while busy with a changing in_data -> no acceptance until in_ready=1; the word transmitted is the in_data value present in the acceptance cycle.
